// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: shared definitions for the multicycle RV32I control unit.
// Holds the base opcode values, the controller state encoding, the pc_sel
// and wb_sel mux encodings, and bit positions of the one-hot opcode class.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU    = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD   = 2'b01;
  localparam logic [1:0] WB_SEL_PC4    = 2'b10;

  localparam int CLS_LUI     = 0;
  localparam int CLS_AUIPC   = 1;
  localparam int CLS_JAL     = 2;
  localparam int CLS_JALR    = 3;
  localparam int CLS_BRANCH  = 4;
  localparam int CLS_LOAD    = 5;
  localparam int CLS_STORE   = 6;
  localparam int CLS_OP_IMM  = 7;
  localparam int CLS_OP      = 8;
  localparam int CLS_FENCE   = 9;
  localparam int CLS_SYSTEM  = 10;
  localparam int CLS_ILLEGAL = 11;
  localparam int NUM_CLS     = 12;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// ctrl_opcode_decode: purely combinational opcode classifier.
// Ports:
//   opcode  in   7         instruction opcode field
//   cls     out  NUM_CLS   one-hot class; CLS_ILLEGAL for anything unknown
module ctrl_opcode_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]         opcode,
  output logic [NUM_CLS-1:0] cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI:    cls[CLS_LUI]     = 1'b1;
      OPC_AUIPC:  cls[CLS_AUIPC]   = 1'b1;
      OPC_JAL:    cls[CLS_JAL]     = 1'b1;
      OPC_JALR:   cls[CLS_JALR]    = 1'b1;
      OPC_BRANCH: cls[CLS_BRANCH]  = 1'b1;
      OPC_LOAD:   cls[CLS_LOAD]    = 1'b1;
      OPC_STORE:  cls[CLS_STORE]   = 1'b1;
      OPC_OP_IMM: cls[CLS_OP_IMM]  = 1'b1;
      OPC_OP:     cls[CLS_OP]      = 1'b1;
      OPC_FENCE:  cls[CLS_FENCE]   = 1'b1;
      OPC_SYSTEM: cls[CLS_SYSTEM]  = 1'b1;
      default:    cls[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencer for a multicycle RV32I datapath.
// Fetches, decodes, executes, optionally accesses data memory and writes
// back, retiring one instruction per pc_we strobe and counting retirements.
//
// Build option: ILLEGAL_OPCODE_TRAP_EN -- when defined, an unknown opcode
// parks the controller in TRAP (illegal=1) until reset; when undefined the
// unknown opcode is retired as a NOP and illegal is tied low.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   instr           instruction word from memory (latched on ir_load)
//   imem_ready      instruction memory data valid
//   dmem_ready      data memory access complete
//   branch_taken    ALU branch compare result
//   imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we   control strobes
//   pc_sel, wb_sel, alu_src_b                             datapath selects
//   state_o         current state encoding
//   illegal         illegal-opcode flag
//   retired         retired-instruction count (wraps)
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ready, latch instr
// DECODE | classify the latched opcode
// EXEC   | ALU step; branches and NOPs retire here
// MEM    | data memory access, held until dmem_ready; stores retire here
// WB     | register write-back and PC update, retire
// TRAP   | illegal opcode seen, frozen until reset
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t               state_q, state_d;
  logic [11:0]          ir_q;
  logic [CNT_W-1:0]     retired_q;
  logic [NUM_CLS-1:0]   cls;
  logic                 rd_nz;
  logic                 is_ldst;
  logic                 is_nop;
  logic                 unused_instr;

  // Only opcode and rd steer the controller; the rest belongs to the datapath.
  assign unused_instr = ^instr[31:12];

  ctrl_opcode_decode u_opcode_decode (
    .opcode (ir_q[6:0]),
    .cls    (cls)
  );

  assign rd_nz   = |ir_q[11:7];
  assign is_ldst = cls[CLS_LOAD] | cls[CLS_STORE];
  assign is_nop  = cls[CLS_FENCE] | cls[CLS_SYSTEM] | cls[CLS_ILLEGAL];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= instr[11:0];
    end
  end

  // pc_we is already forced low during reset, so an aborted instruction
  // can never bump the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (pc_we) begin
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (imem_ready) state_d = DECODE;
      DECODE: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        if (cls[CLS_ILLEGAL]) state_d = TRAP;
        else                  state_d = EXEC;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        if (cls[CLS_BRANCH] || is_nop) state_d = FETCH;
        else if (is_ldst)              state_d = MEM;
        else                           state_d = WB;
      end
      MEM: begin
        if (dmem_ready) state_d = cls[CLS_STORE] ? FETCH : WB;
      end
      WB:   state_d = FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    wb_sel    = WB_SEL_ALU;
    alu_src_b = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      EXEC: begin
        if (cls[CLS_BRANCH]) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
        end else if (is_nop) begin
          pc_we  = 1'b1;
        end else begin
          alu_src_b = ~cls[CLS_OP];
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls[CLS_STORE];
        pc_we    = cls[CLS_STORE] & dmem_ready;
      end
      WB: begin
        reg_we = rd_nz;
        pc_we  = 1'b1;
        if (cls[CLS_LOAD])                     wb_sel = WB_SEL_LOAD;
        else if (cls[CLS_JAL] | cls[CLS_JALR]) wb_sel = WB_SEL_PC4;
        if (cls[CLS_JAL])       pc_sel = PC_SEL_TARGET;
        else if (cls[CLS_JALR]) pc_sel = PC_SEL_JALR;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      TRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
    // Reset overrides immediately, before the state register has updated.
    if (rst) begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_SEL_PLUS4;
      wb_sel    = WB_SEL_ALU;
      alu_src_b = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state_o = rst ? FETCH : state_q;
  assign retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import rv32i_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          imem_ready, dmem_ready, branch_taken;
  logic          imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we;
  logic [1:0]    pc_sel, wb_sel;
  logic          alu_src_b;
  logic [2:0]    state_o;
  logic          illegal;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;
  int st_log[64];

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .state_o(state_o), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Transaction-level expectations from the instruction class alone.
  task automatic model(input logic [31:0] ins, input int iw, input int dw, input bit bt,
                       output int cyc, output int pcs, output int wbs, output int rwe,
                       output int dreq, output int dwe, output int alu);
    bit rdnz;
    rdnz = (ins[11:7] != 5'd0);
    cyc = 1 + iw + 2; pcs = 0; wbs = 0; rwe = 0; dreq = 0; dwe = 0; alu = 0;
    case (ins[6:0])
      7'h37, 7'h17, 7'h13: begin cyc += 1; alu = 1; rwe = int'(rdnz); end
      7'h33:               begin cyc += 1; rwe = int'(rdnz); end
      7'h6F:               begin cyc += 1; alu = 1; pcs = 1; wbs = 2; rwe = int'(rdnz); end
      7'h67:               begin cyc += 1; alu = 1; pcs = 2; wbs = 2; rwe = int'(rdnz); end
      7'h63:               pcs = bt ? 1 : 0;
      7'h03:               begin cyc += 2 + dw; alu = 1; dreq = dw + 1; wbs = 1; rwe = int'(rdnz); end
      7'h23:               begin cyc += 1 + dw; alu = 1; dreq = dw + 1; dwe = dw + 1; end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input bit bt, input string nm);
    int cyc = 0, iseen = 0, dseen = 0;
    int n_dreq = 0, n_dwe = 0, n_rwe = 0, n_alu = 0, n_ld = 0, n_ovl = 0, n_ill = 0;
    int pcs_at = 0, wbs_at = 0;
    int e_cyc, e_pcs, e_wbs, e_rwe, e_dreq, e_dwe, e_alu;
    bit loaded = 0, done = 0;
    model(ins, iw, dw, bt, e_cyc, e_pcs, e_wbs, e_rwe, e_dreq, e_dwe, e_alu);
    while (!done && cyc < 64) begin
      @(negedge clk);
      instr        = loaded ? $urandom : ins;
      branch_taken = bt;
      imem_ready   = imem_req && (iseen >= iw);
      dmem_ready   = dmem_req && (dseen >= dw);
      #1;
      st_log[cyc] = int'(state_o);
      if (cyc == 0) begin
        chk({nm, "_start_state"}, 32'(state_o), 32'(FETCH));
        chk({nm, "_retired"}, 32'(retired), 32'(exp_ret));
      end
      if (imem_req) iseen++;
      if (dmem_req) begin dseen++; n_dreq++; end
      if (dmem_we) n_dwe++;
      if (reg_we) n_rwe++;
      if (alu_src_b) n_alu++;
      if (ir_load) begin n_ld++; loaded = 1; end
      if (imem_req && dmem_req) n_ovl++;
      if (illegal) n_ill++;
      if (pc_we) begin
        done = 1;
        pcs_at = int'(pc_sel);
        wbs_at = int'(wb_sel);
      end
      cyc++;
    end
    chk({nm, "_retire_seen"}, 32'(done), 32'd1);
    chk({nm, "_cycles"},  32'(cyc),    32'(e_cyc));
    chk({nm, "_pc_sel"},  32'(pcs_at), 32'(e_pcs));
    chk({nm, "_wb_sel"},  32'(wbs_at), 32'(e_wbs));
    chk({nm, "_reg_we"},  32'(n_rwe),  32'(e_rwe));
    chk({nm, "_dmem_req"},32'(n_dreq), 32'(e_dreq));
    chk({nm, "_dmem_we"}, 32'(n_dwe),  32'(e_dwe));
    chk({nm, "_alu_src"}, 32'(n_alu),  32'(e_alu));
    chk({nm, "_ir_load"}, 32'(n_ld),   32'd1);
    chk({nm, "_overlap"}, 32'(n_ovl),  32'd0);
    chk({nm, "_illegal"}, 32'(n_ill),  32'd0);
    exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[11];
    logic [31:0] r;
    int idx, nops;
    bit hit;
    int n;
    logic [4:0] rd;

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    rst = 1'b1; instr = 32'h0; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_state",   32'(state_o), 32'(FETCH));
      chk("rst_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, alu_src_b}), 32'd0);
      chk("rst_sels",    32'({pc_sel, wb_sel}), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("post_rst_state", 32'(state_o), 32'(FETCH));
    chk("post_rst_imem_req", 32'(imem_req), 32'd1);

    // Abort a store while its data access is still pending.
    hit = 0; n = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      instr = 32'h0020A023; imem_ready = imem_req; dmem_ready = 1'b0;
      #1;
      if (dmem_req) n++;
      if (n == 2) hit = 1;
    end
    chk("abort_reach_mem", 32'(hit), 32'd1);
    rst = 1'b1; #1;
    chk("abort_pc_we", 32'(pc_we), 32'd0);
    chk("abort_dmem_req_in_rst", 32'(dmem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("abort_state", 32'(state_o), 32'(FETCH));
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    chk("abort_imem_req", 32'(imem_req), 32'd1);
    chk("abort_retired", 32'(retired), 32'd0);
    exp_ret = 0;

    run_instr(32'h00100093, 0, 0, 1'b0, "addi_x1");
    chk("addi_s0", 32'(st_log[0]), 32'(FETCH));
    chk("addi_s1", 32'(st_log[1]), 32'(DECODE));
    chk("addi_s2", 32'(st_log[2]), 32'(EXEC));
    chk("addi_s3", 32'(st_log[3]), 32'(WB));
    run_instr(32'h0000A103, 0, 3, 1'b0, "lw");
    run_instr(32'h00000063, 0, 0, 1'b1, "beq_t");
    run_instr(32'h00000063, 0, 0, 1'b0, "beq_nt");
    run_instr(32'h00000013, 0, 0, 1'b0, "addi_x0");
    run_instr(32'h0020A023, 1, 2, 1'b0, "sw");

`ifdef ILLEGAL_OPCODE_TRAP_EN
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      instr = 32'h0000007F; imem_ready = imem_req; dmem_ready = 1'b0;
      #1;
      if (state_o == 3'(TRAP)) hit = 1;
    end
    chk("trap_reach", 32'(hit), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr = $urandom; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
      #1;
      chk("trap_state", 32'(state_o), 32'(TRAP));
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, alu_src_b, pc_sel, wb_sel}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1; #1;
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
    chk("trap_exit_state", 32'(state_o), 32'(FETCH));
    chk("trap_exit_retired", 32'(retired), 32'd0);
    exp_ret = 0;
    nops = 11;
`else
    run_instr(32'h0000007F, 0, 0, 1'b0, "illegal_nop");
    nops = 12;
`endif

    for (int k = 0; k < 60; k++) begin
      idx = $urandom_range(0, nops - 1);
      r = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (idx < 11) r = {r[31:12], rd, ops[idx]};
      else          r = {r[31:12], rd, 7'h7F};
      run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd");
    end

    @(negedge clk); #1;
    chk("final_retired", 32'(retired), 32'(exp_ret));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
